// File: rtl/bladd_seq_pkg.sv
// Shared types and constants for the bit-line addition sequencer.
//   state_e    : sequencer states
//   *_DEF      : default row-address and nibble-count widths
//   NIBBLE_W   : width of one operand slice held per SRAM row
//   STEP_LAT   : cycles spent per nibble (activate, sense, write back)
package bladd_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned LEN_W_DEF  = 3;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned STEP_LAT   = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACT   = 3'd1,
        SENSE = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/bladd_addr_gen.sv
// Row address generator for the bit-line addition sequencer.
// Latches the three base rows and the nibble count at command accept, keeps
// the nibble index k, and produces wrapped row addresses (base + k).
//   clk, rst              : clock, async active-high reset
//   load                  : command accepted; latch bases/len, clear k
//   inc                   : advance k to the next nibble
//   src_a_in/src_b_in/dst_in/len_in : command fields
//   wl_addr_a/wl_addr_b   : activated rows for nibble k
//   wr_addr               : destination row for nibble k
//   last_step             : k has reached the final nibble
module bladd_addr_gen
    import bladd_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] src_a_in,
    input  logic [ADDR_W-1:0] src_b_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] wl_addr_a,
    output logic [ADDR_W-1:0] wl_addr_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_step
);

    logic [ADDR_W-1:0] src_a_q, src_a_d;
    logic [ADDR_W-1:0] src_b_q, src_b_d;
    logic [ADDR_W-1:0] dst_q,   dst_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [LEN_W-1:0]  k_q,     k_d;

    // Base/count capture and step advance
    always_comb begin
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_d   = dst_q;
        len_d   = len_q;
        k_d     = k_q;
        if (load) begin
            src_a_d = src_a_in;
            src_b_d = src_b_in;
            dst_d   = dst_in;
            len_d   = len_in;
            k_d     = '0;
        end else if (inc) begin
            k_d = k_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            k_q     <= '0;
        end else begin
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            k_q     <= k_d;
        end
    end

    // Addition truncates to ADDR_W, so running past the top row wraps to row 0
    assign wl_addr_a = src_a_q + ADDR_W'(k_q);
    assign wl_addr_b = src_b_q + ADDR_W'(k_q);
    assign wr_addr   = dst_q   + ADDR_W'(k_q);
    assign last_step = (k_q == len_q);

endmodule

// File: rtl/bladd_seq_ctrl.sv
// In-array bit-line addition sequencer.
// For each nibble: dual-wordline activate rows A and B, latch sensed BL/BLB
// into the external CLA2 slice, write SUM back to the destination row and
// chain the carry into the next nibble.
// Optional abort support is compiled in with `define BLADD_SEQ_ABORT_EN.
//   clk, rst                         : clock, async active-high reset
//   cmd_valid/cmd_ready              : command handshake (ready only when idle)
//   cmd_src_a/cmd_src_b/cmd_dst      : nibble-0 rows of A, B and result
//   cmd_len/cmd_cin                  : nibble count minus one, carry-in
//   wl_en/wl_addr_a/wl_addr_b        : dual-wordline activation
//   bl_in/blb_in                     : sensed A&B / ~(A|B), valid after wl_en
//   add_bl/add_blb/add_cin           : registered operands to CLA2
//   add_sum/add_cout                 : CLA2 results
//   wr_en/wr_addr/wr_data            : SUM write-back
//   done/carry_out                   : completion pulse, final carry
//   abort/aborted (optional)         : stop request, abort status
module bladd_seq_ctrl
    import bladd_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
`ifdef BLADD_SEQ_ABORT_EN
    input  logic                abort,
    output logic                aborted,
`endif
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_src_a,
    input  logic [ADDR_W-1:0]   cmd_src_b,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                cmd_cin,
    output logic                wl_en,
    output logic [ADDR_W-1:0]   wl_addr_a,
    output logic [ADDR_W-1:0]   wl_addr_b,
    input  logic [NIBBLE_W-1:0] bl_in,
    input  logic [NIBBLE_W-1:0] blb_in,
    output logic [NIBBLE_W-1:0] add_bl,
    output logic [NIBBLE_W-1:0] add_blb,
    output logic                add_cin,
    input  logic [NIBBLE_W-1:0] add_sum,
    input  logic                add_cout,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [NIBBLE_W-1:0] wr_data,
    output logic                done,
    output logic                carry_out
);

    state_e                state_q, state_d;
    logic                  carry_q, carry_d;
    logic [NIBBLE_W-1:0]   bl_q, bl_d;
    logic [NIBBLE_W-1:0]   blb_q, blb_d;
    logic                  carry_out_q, carry_out_d;
    logic                  accept_c;
    logic                  inc_c;
    logic                  last_step_c;

    assign accept_c = cmd_valid & (state_q == IDLE);

`ifdef BLADD_SEQ_ABORT_EN
    logic abort_c;
    logic aborted_q, aborted_d;

    // Abort only acts while an operation is in flight
    assign abort_c = abort & ((state_q == ACT) || (state_q == SENSE) || (state_q == WB));

    always_comb begin
        aborted_d = aborted_q;
        if (accept_c) begin
            aborted_d = 1'b0;
        end else if (abort_c) begin
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted = aborted_q;
`endif

    // Next-state, datapath capture and per-state strobes
    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        bl_d        = bl_q;
        blb_d       = blb_q;
        carry_out_d = carry_out_q;
        cmd_ready   = 1'b0;
        wl_en       = 1'b0;
        wr_en       = 1'b0;
        done        = 1'b0;
        inc_c       = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    carry_d     = cmd_cin;
                    carry_out_d = 1'b0;
                    state_d     = ACT;
                end
            end
            ACT: begin
                wl_en   = 1'b1;
                state_d = SENSE;
            end
            SENSE: begin
                bl_d    = bl_in;
                blb_d   = blb_in;
                state_d = WB;
            end
            WB: begin
                wr_en   = 1'b1;
                carry_d = add_cout;
                if (last_step_c) begin
                    // Publish the final carry on DONE entry so it is valid with the pulse
                    carry_out_d = add_cout;
                    state_d     = DONE;
                end else begin
                    inc_c   = 1'b1;
                    state_d = ACT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef BLADD_SEQ_ABORT_EN
        // Aborted nibble is neither written nor allowed to update the carry
        if (abort_c) begin
            wr_en       = 1'b0;
            inc_c       = 1'b0;
            carry_d     = carry_q;
            carry_out_d = 1'b0;
            state_d     = DONE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            bl_q        <= '0;
            blb_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            bl_q        <= bl_d;
            blb_q       <= blb_d;
            carry_out_q <= carry_out_d;
        end
    end

    bladd_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_c),
        .inc       (inc_c),
        .src_a_in  (cmd_src_a),
        .src_b_in  (cmd_src_b),
        .dst_in    (cmd_dst),
        .len_in    (cmd_len),
        .wl_addr_a (wl_addr_a),
        .wl_addr_b (wl_addr_b),
        .wr_addr   (wr_addr),
        .last_step (last_step_c)
    );

    assign add_bl    = bl_q;
    assign add_blb   = blb_q;
    assign add_cin   = carry_q;
    assign wr_data   = add_sum;
    assign carry_out = carry_out_q;

endmodule

// File: doc/bladd_seq_ctrl.md
Name: bladd_seq_ctrl

Overview:
- Sequencer for in-array bit-line addition. Runs a multi-nibble add of two operands stored nibble-per-row in the SRAM sub-array.
- Per nibble step:
  - fires dual-wordline activation on rows A and B;
  - latches the sensed BL (A&B) and BLB (~(A|B)) into the external 4-bit CLA2 slice;
  - chains the carry through a register;
  - writes SUM back to the destination row.
- Sits between the cache-compute command decoder and the sub-array/adder periphery.

Parameters:
- ADDR_W, 6, row address width; all row addresses wrap modulo 2^ADDR_W.
- LEN_W, 3, width of nibble-count field; max operand = 2^LEN_W nibbles (32 bits at default).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle; command accepted when cmd_valid & cmd_ready.
- cmd_src_a  in  ADDR_W  row of nibble 0 of operand A.
- cmd_src_b  in  ADDR_W  row of nibble 0 of operand B.
- cmd_dst  in  ADDR_W  row of nibble 0 of result.
- cmd_len  in  LEN_W  number of nibbles minus 1.
- cmd_cin  in  1  carry-in of nibble 0.
- wl_en  out  1  dual-wordline activate strobe.
- wl_addr_a  out  ADDR_W  first activated row.
- wl_addr_b  out  ADDR_W  second activated row.
- bl_in  in  4  sensed BL, valid the cycle after wl_en.
- blb_in  in  4  sensed BLB, valid the cycle after wl_en.
- add_bl  out  4  registered BL to CLA2.
- add_blb  out  4  registered BLB to CLA2.
- add_cin  out  1  carry register to CLA2.
- add_sum  in  4  CLA2 SUM (combinational from add_* outputs).
- add_cout  in  1  CLA2 COUT.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  write row.
- wr_data  out  4  write data (= add_sum).
- done  out  1  one-cycle pulse at completion.
- carry_out  out  1  final carry; held until next accept.

Behaviour:
- Reset values:
  - FSM = IDLE, cmd_ready = 1.
  - All strobes and done = 0.
  - All address/data outputs = 0, add_bl/add_blb/add_cin = 0, carry_out = 0, step counter = 0.
- Reset asserted mid-operation: abandon the operation immediately. No further wl_en/wr_en; a partially written destination is not repaired.
- States:
  - IDLE: cmd_ready = 1. On accept, latch src_a/src_b/dst/len, carry_reg <= cmd_cin, k <= 0, clear carry_out → ACT.
  - ACT: wl_en = 1, wl_addr_a = src_a+k, wl_addr_b = src_b+k → SENSE.
  - SENSE: add_bl <= bl_in, add_blb <= blb_in → WB.
  - WB:
    - wr_en = 1, wr_addr = dst+k, wr_data = add_sum.
    - carry_reg <= add_cout.
    - If k == len → DONE, else k <= k+1 → ACT.
  - DONE:
    - done = 1, carry_out = carry_reg → IDLE.
    - cmd_ready stays 0 in DONE.
- Timing: 3 cycles per nibble; accept-to-done = 3*(len+1)+1 cycles. Next accept is possible the cycle after done.
- add_cin always equals carry_reg. add_bl/add_blb hold their value outside SENSE.
- Address arithmetic: (base + k) mod 2^ADDR_W. Wrap past the top row is legal and silent.
- Aliasing: dst == src_a or src_b is legal. Each nibble is read before it is written, and never re-read.
- cmd_valid while busy: ignored (ready = 0). Command fields are sampled only at accept.
- wl_en and wr_en are never asserted in the same cycle.

Optional Feature:
- Macro: BLADD_SEQ_ABORT_EN.
- With the macro defined:
  - adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort sampled high in ACT, SENSE or WB → next state DONE.
  - wr_en is suppressed in that cycle if in WB.
  - done pulses with aborted = 1 and carry_out = 0. aborted clears on next accept.
  - abort in IDLE/DONE has no effect.
- Without the macro: neither port exists; behaviour as above.

Decomposition:
- Package bladd_seq_pkg:
  - state enum {IDLE, ACT, SENSE, WB, DONE};
  - default ADDR_W/LEN_W constants;
  - NIBBLE_W = 4;
  - step-latency constant = 3.
- One sub-module, bladd_addr_gen: holds the three latched bases and k, produces wrapped wl_addr_a/wl_addr_b/wr_addr and the last_step flag.
- The FSM, carry register and BL/BLB latches live in the top module.

Test Plan:
- Bench SRAM model: bl_in = A&B, blb_in = ~(A|B) of activated rows; real CLA2 instance.
- Single nibble: A = 0x9, B = 0x8, cin = 0, len = 0 → one write of 0x1 to dst, carry_out = 1, done at cycle 4 after accept.
- 16-bit: A = 0x00FF, B = 0x0001, len = 3 → dst..dst+3 written 0,0,1,0; carry_out = 0; done 13 cycles after accept.
- Overflow: A = 0xFFFF, B = 0x0001, cin = 0 → all four nibbles 0, carry_out = 1.
- Address wrap + aliasing: src_a = 62, src_b = 10, dst = 62, len = 3, A = 0x1234, B = 0x1111, cin = 1 → rows 62, 63, 0, 1 hold 0x2346 nibbles LSB-first; no wl_en/wr_en overlap.
- Reset mid-operation: assert rst during SENSE of nibble 1 → all outputs return to reset values asynchronously; cmd_ready = 1 the first cycle after deassert; a new command completes correctly.
- BLADD_SEQ_ABORT_EN: abort in WB of nibble 2 of len = 3 → no write to dst+2, done with aborted = 1, carry_out = 0; busy-time cmd_valid never accepted.
